// File: rtl/ttt_pkg.sv
// Shared constants, FSM state type and saturation helper for the TTT input aggregator.
package ttt_pkg;

    localparam logic [3:0] INSTR_ADD_GOOD  = 4'b0000;
    localparam logic [3:0] INSTR_ADD_BAD   = 4'b0001;
    localparam logic [3:0] INSTR_TALLY     = 4'b1000;
    localparam logic [3:0] INSTR_COUNTDOWN = 4'b1001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADD_GOOD,
        ST_ADD_BAD,
        ST_TALLY,
        ST_COUNTDOWN
    } seq_state_t;

    // Clamp a signed value into the signed range of a 'bits'-wide word.
    function automatic int sat_resize(input int value, input int bits);
        int hi;
        int lo;
        hi = (1 << (bits - 1)) - 1;
        lo = -(1 << (bits - 1));
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
    endfunction

endpackage

// File: rtl/ttt_input_aggregator_if.sv
// Configuration port and processor-facing instruction bus of the aggregator.
interface ttt_input_aggregator_if #(
    parameter int NEW_TOKEN_BITS   = 4,
    parameter int ADDR_BITS        = 2,
    parameter int INSTRUCTION_BITS = 4
);
    logic                               cfg_we;
    logic [ADDR_BITS-1:0]               cfg_addr;
    logic signed [NEW_TOKEN_BITS-1:0]   cfg_weight;
    logic                               cfg_is_bad;
    logic                               proc_enable;
    logic [INSTRUCTION_BITS-1:0]        proc_instruction;
    logic signed [NEW_TOKEN_BITS-1:0]   good_tokens_out;
    logic signed [NEW_TOKEN_BITS-1:0]   bad_tokens_out;

    // Environment side: writes the weight table, observes the processor bus.
    modport master (
        output cfg_we, cfg_addr, cfg_weight, cfg_is_bad,
        input  proc_enable, proc_instruction, good_tokens_out, bad_tokens_out
    );

    // Aggregator side.
    modport slave (
        input  cfg_we, cfg_addr, cfg_weight, cfg_is_bad,
        output proc_enable, proc_instruction, good_tokens_out, bad_tokens_out
    );
endinterface

// File: rtl/ttt_weighted_accumulator.sv
// One token pool: weighted sum of selected source events, saturating window
// accumulator, and snapshot/reload when the window closes.
module ttt_weighted_accumulator
    import ttt_pkg::*;
#(
    parameter int NUM_SOURCES    = 4,
    parameter int NEW_TOKEN_BITS = 4,
    parameter int ACC_BITS       = 8
) (
    input  logic                                        clock,
    input  logic                                        reset,
    input  logic [NUM_SOURCES-1:0][NEW_TOKEN_BITS-1:0]  weights,
    input  logic [NUM_SOURCES-1:0]                      select,
    input  logic [NUM_SOURCES-1:0]                      start,
    input  logic [NUM_SOURCES-1:0]                      stop,
    input  logic                                        snap,
    output logic signed [NEW_TOKEN_BITS-1:0]            snapshot,
    output logic                                        overflow_pulse
);

    logic signed [ACC_BITS-1:0] acc_q;
    int sum;
    int acc_sum;
    int acc_sat;
    int load_sat;
    int snap_sat;

    // Sum this cycle's contributions and form the saturated next/snapshot values.
    always_comb begin
        // NOTE: every combinational result gets a default first so no latch is inferred.
        sum = 0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            // A start and stop together cancel out.
            if (select[i] && (start[i] ^ stop[i])) begin
                if (start[i]) sum = sum + int'($signed(weights[i]));
                else          sum = sum - int'($signed(weights[i]));
            end
        end
        acc_sum        = int'(acc_q) + sum;
        acc_sat        = sat_resize(acc_sum, ACC_BITS);
        load_sat       = sat_resize(sum, ACC_BITS);
        snap_sat       = sat_resize(int'(acc_q), NEW_TOKEN_BITS);
        snapshot       = NEW_TOKEN_BITS'(snap_sat);
        overflow_pulse = snap ? ((snap_sat != int'(acc_q)) || (load_sat != sum))
                              : (acc_sat != acc_sum);
    end

    // Window accumulator: reload with the tick-cycle contribution on snapshot.
    always_ff @(posedge clock) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (reset)     acc_q <= '0;
        else if (snap) acc_q <= ACC_BITS'(load_sat);
        else           acc_q <= ACC_BITS'(acc_sat);
    end

endmodule

// File: rtl/ttt_input_aggregator.sv
// Feeds one TTT processor: weight table, good/bad pools, and the four-step
// add-good / add-bad / tally / countdown sequence issued on every tick.
module ttt_input_aggregator
    import ttt_pkg::*;
#(
    parameter int NUM_SOURCES      = 4,
    parameter int NEW_TOKEN_BITS   = 4,
    parameter int ACC_BITS         = 8,
    parameter int INSTRUCTION_BITS = 4,
    parameter int ADDR_BITS        = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    tick,
    input  logic [NUM_SOURCES-1:0]  src_start,
    input  logic [NUM_SOURCES-1:0]  src_stop,
    ttt_input_aggregator_if.slave   bus,
    output logic                    busy,
    output logic                    overflow,
    output logic                    tick_overrun
);

    logic [NUM_SOURCES-1:0][NEW_TOKEN_BITS-1:0] weight_q;
    logic [NUM_SOURCES-1:0]                     is_bad_q;

    seq_state_t                         state_q;
    seq_state_t                         state_d;
    logic                               accept;
    logic [INSTRUCTION_BITS-1:0]        instr_d;
    logic signed [NEW_TOKEN_BITS-1:0]   good_snap;
    logic signed [NEW_TOKEN_BITS-1:0]   bad_snap;
    logic                               good_ovf;
    logic                               bad_ovf;

    // Weight table; out-of-range addresses are dropped.
    always_ff @(posedge clock) begin
        // NOTE: the table is only a few flops, so it is reset like ordinary state.
        if (reset) begin
            weight_q <= '0;
            is_bad_q <= '0;
        end else if (bus.cfg_we && (int'(bus.cfg_addr) < NUM_SOURCES)) begin
            weight_q[bus.cfg_addr] <= bus.cfg_weight;
            is_bad_q[bus.cfg_addr] <= bus.cfg_is_bad;
        end
    end

    ttt_weighted_accumulator #(
        .NUM_SOURCES    (NUM_SOURCES),
        .NEW_TOKEN_BITS (NEW_TOKEN_BITS),
        .ACC_BITS       (ACC_BITS)
    ) u_good_pool (
        .clock          (clock),
        .reset          (reset),
        .weights        (weight_q),
        .select         (~is_bad_q),
        .start          (src_start),
        .stop           (src_stop),
        .snap           (accept),
        .snapshot       (good_snap),
        .overflow_pulse (good_ovf)
    );

    ttt_weighted_accumulator #(
        .NUM_SOURCES    (NUM_SOURCES),
        .NEW_TOKEN_BITS (NEW_TOKEN_BITS),
        .ACC_BITS       (ACC_BITS)
    ) u_bad_pool (
        .clock          (clock),
        .reset          (reset),
        .weights        (weight_q),
        .select         (is_bad_q),
        .start          (src_start),
        .stop           (src_stop),
        .snap           (accept),
        .snapshot       (bad_snap),
        .overflow_pulse (bad_ovf)
    );

    // Next state and the instruction for that state; a tick is only taken in IDLE.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        instr_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    state_d = ST_ADD_GOOD;
                    accept  = 1'b1;
                end
            end
            ST_ADD_GOOD:  state_d = ST_ADD_BAD;
            ST_ADD_BAD:   state_d = ST_TALLY;
            ST_TALLY:     state_d = ST_COUNTDOWN;
            ST_COUNTDOWN: state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
        case (state_d)
            ST_ADD_GOOD:  instr_d = INSTRUCTION_BITS'(INSTR_ADD_GOOD);
            ST_ADD_BAD:   instr_d = INSTRUCTION_BITS'(INSTR_ADD_BAD);
            ST_TALLY:     instr_d = INSTRUCTION_BITS'(INSTR_TALLY);
            ST_COUNTDOWN: instr_d = INSTRUCTION_BITS'(INSTR_COUNTDOWN);
            default:      instr_d = '0;
        endcase
    end

    // State, registered processor outputs and sticky flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q              <= ST_IDLE;
            bus.proc_enable      <= 1'b0;
            bus.proc_instruction <= '0;
            bus.good_tokens_out  <= '0;
            bus.bad_tokens_out   <= '0;
            busy                 <= 1'b0;
            overflow             <= 1'b0;
            tick_overrun         <= 1'b0;
        end else begin
            state_q              <= state_d;
            bus.proc_enable      <= (state_d != ST_IDLE);
            bus.proc_instruction <= instr_d;
            busy                 <= (state_d != ST_IDLE);
            if (accept) begin
                bus.good_tokens_out <= good_snap;
                bus.bad_tokens_out  <= bad_snap;
            end else if (state_d == ST_IDLE) begin
                bus.good_tokens_out <= '0;
                bus.bad_tokens_out  <= '0;
            end
            overflow     <= overflow | good_ovf | bad_ovf;
            tick_overrun <= tick_overrun | (tick && (state_q != ST_IDLE));
        end
    end

endmodule

// File: tb/tb_ttt_input_aggregator.sv
// Self-checking bench for ttt_input_aggregator (three sources so that address 3
// is out of range), with a behavioural reference model of windows and sequences.
module tb_ttt_input_aggregator;

    logic       clock;
    logic       reset;
    logic       tick;
    logic [2:0] src_start;
    logic [2:0] src_stop;
    logic       busy;
    logic       overflow;
    logic       tick_overrun;

    int checks   = 0;
    int failures = 0;

    ttt_input_aggregator_if #(.NEW_TOKEN_BITS(4), .ADDR_BITS(2), .INSTRUCTION_BITS(4)) bus ();

    ttt_input_aggregator #(
        .NUM_SOURCES      (3),
        .NEW_TOKEN_BITS   (4),
        .ACC_BITS         (8),
        .INSTRUCTION_BITS (4),
        .ADDR_BITS        (2)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .tick         (tick),
        .src_start    (src_start),
        .src_stop     (src_stop),
        .bus          (bus),
        .busy         (busy),
        .overflow     (overflow),
        .tick_overrun (tick_overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    int m_w[3];
    bit m_bad[3];
    int m_acc_g, m_acc_b;
    int m_phase;              // 0 = idle, 1..4 = sequence step
    int m_out_g, m_out_b;
    bit m_ovf, m_ovr;
    int exp_instr[5] = '{0, 0, 1, 8, 9};

    function automatic int sat(input int v, input int bits);
        int hi = (1 << (bits - 1)) - 1;
        int lo = -(1 << (bits - 1));
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    task automatic model_edge(input bit rst_i, input bit tk, input logic [2:0] st,
                              input logic [2:0] sp, input bit we, input int addr,
                              input int wt, input bit bd);
        int cg = 0;
        int cb = 0;
        int s;
        if (rst_i) begin
            for (int i = 0; i < 3; i++) begin m_w[i] = 0; m_bad[i] = 0; end
            m_acc_g = 0; m_acc_b = 0; m_phase = 0;
            m_out_g = 0; m_out_b = 0; m_ovf = 0; m_ovr = 0;
            return;
        end
        for (int i = 0; i < 3; i++) begin
            s = (st[i] ? m_w[i] : 0) - (sp[i] ? m_w[i] : 0);
            if (m_bad[i]) cb += s; else cg += s;
        end
        if (m_phase == 0 && tk) begin
            m_out_g = sat(m_acc_g, 4);
            m_out_b = sat(m_acc_b, 4);
            if (m_out_g != m_acc_g || m_out_b != m_acc_b) m_ovf = 1;
            if (sat(cg, 8) != cg || sat(cb, 8) != cb) m_ovf = 1;
            m_acc_g = sat(cg, 8);
            m_acc_b = sat(cb, 8);
            m_phase = 1;
        end else begin
            if (tk) m_ovr = 1;
            if (sat(m_acc_g + cg, 8) != m_acc_g + cg) m_ovf = 1;
            if (sat(m_acc_b + cb, 8) != m_acc_b + cb) m_ovf = 1;
            m_acc_g = sat(m_acc_g + cg, 8);
            m_acc_b = sat(m_acc_b + cb, 8);
            if (m_phase != 0) begin
                m_phase++;
                if (m_phase == 5) begin m_phase = 0; m_out_g = 0; m_out_b = 0; end
            end
        end
        if (we && addr < 3) begin
            m_w[addr]   = wt;
            m_bad[addr] = bd;
        end
    endtask

    // Drive one cycle of inputs, clock it into DUT and model, return at the negedge.
    task automatic step(input bit rst_i, input bit tk, input logic [2:0] st,
                        input logic [2:0] sp, input bit we, input int addr,
                        input int wt, input bit bd);
        reset          = rst_i;
        tick           = tk;
        src_start      = st;
        src_stop       = sp;
        bus.cfg_we     = we;
        bus.cfg_addr   = addr[1:0];
        bus.cfg_weight = wt[3:0];
        bus.cfg_is_bad = bd;
        @(posedge clock);
        model_edge(rst_i, tk, st, sp, we, addr, wt, bd);
        @(negedge clock);
        reset = 1'b0; tick = 1'b0; src_start = '0; src_stop = '0; bus.cfg_we = 1'b0;
    endtask

    task automatic idle();
        step(0, 0, 3'b000, 3'b000, 0, 0, 0, 0);
    endtask

    task automatic cfg(input int addr, input int wt, input bit bd);
        step(0, 0, 3'b000, 3'b000, 1, addr, wt, bd);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        step(1, 0, 3'b000, 3'b000, 0, 0, 0, 0);
        step(1, 0, 3'b000, 3'b000, 0, 0, 0, 0);
        checks++; if (bus.proc_enable !== 1'b0) begin failures++; $display("FAIL reset_enable got=%b exp=0", bus.proc_enable); end
        checks++; if (bus.proc_instruction !== 4'b0000) begin failures++; $display("FAIL reset_instr got=%b exp=0000", bus.proc_instruction); end
        checks++; if (bus.good_tokens_out !== 4'sd0 || bus.bad_tokens_out !== 4'sd0) begin failures++; $display("FAIL reset_tokens got=%0d/%0d exp=0/0", bus.good_tokens_out, bus.bad_tokens_out); end
        checks++; if ({busy, overflow, tick_overrun} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {busy, overflow, tick_overrun}); end
        // Load a weight and some events, start a sequence, then reset mid-way.
        cfg(0, 3, 0);
        step(0, 0, 3'b001, 3'b000, 0, 0, 0, 0);
        step(0, 1, 3'b001, 3'b000, 0, 0, 0, 0);
        idle();
        step(0, 0, 3'b001, 3'b000, 0, 0, 0, 0);
        checks++; if (bus.proc_enable !== 1'b1) begin failures++; $display("FAIL pre_reset_enable got=%b exp=1", bus.proc_enable); end
        step(1, 0, 3'b000, 3'b000, 0, 0, 0, 0);
        checks++; if ({bus.proc_enable, busy} !== 2'b00 || bus.proc_instruction !== 4'b0000) begin failures++; $display("FAIL midseq_reset got en=%b busy=%b instr=%b exp=0/0/0000", bus.proc_enable, busy, bus.proc_instruction); end
        checks++; if (bus.good_tokens_out !== 4'sd0) begin failures++; $display("FAIL midseq_reset_good got=%0d exp=0", bus.good_tokens_out); end
        idle();
        checks++; if (bus.proc_enable !== 1'b0) begin failures++; $display("FAIL post_reset_enable got=%b exp=0", bus.proc_enable); end
        step(0, 1, 3'b000, 3'b000, 0, 0, 0, 0);
        checks++; if (bus.proc_enable !== 1'b1 || bus.good_tokens_out !== 4'sd0 || bus.bad_tokens_out !== 4'sd0) begin failures++; $display("FAIL post_reset_seq got en=%b good=%0d bad=%0d exp=1/0/0", bus.proc_enable, bus.good_tokens_out, bus.bad_tokens_out); end
        repeat (4) idle();
    endtask

    task automatic test_basic();
        int exp_seq[4] = '{0, 1, 8, 9};
        cfg(0, 3, 0);
        cfg(1, 2, 1);
        step(0, 0, 3'b011, 3'b000, 0, 0, 0, 0);
        step(0, 1, 3'b000, 3'b000, 0, 0, 0, 0);
        for (int p = 0; p < 4; p++) begin
            checks++;
            if (int'(bus.proc_instruction) !== exp_seq[p] || bus.proc_enable !== 1'b1 || busy !== 1'b1) begin
                failures++; $display("FAIL basic_phase%0d got instr=%b en=%b busy=%b exp instr=%0d en=1 busy=1", p, bus.proc_instruction, bus.proc_enable, busy, exp_seq[p]);
            end
            checks++;
            if (int'(bus.good_tokens_out) !== 3 || int'(bus.bad_tokens_out) !== 2) begin
                failures++; $display("FAIL basic_tokens%0d got=%0d/%0d exp=3/2", p, bus.good_tokens_out, bus.bad_tokens_out);
            end
            idle();
        end
        checks++; if (busy !== 1'b0 || bus.proc_enable !== 1'b0 || bus.good_tokens_out !== 4'sd0) begin failures++; $display("FAIL basic_end got busy=%b en=%b good=%0d exp=0/0/0", busy, bus.proc_enable, bus.good_tokens_out); end
    endtask

    task automatic test_saturation();
        cfg(0, 7, 0);
        repeat (3) step(0, 0, 3'b001, 3'b000, 0, 0, 0, 0);
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL sat_pre_overflow got=%b exp=0", overflow); end
        step(0, 1, 3'b000, 3'b000, 0, 0, 0, 0);
        checks++; if (int'(bus.good_tokens_out) !== 7) begin failures++; $display("FAIL sat_pos got=%0d exp=7", bus.good_tokens_out); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL sat_overflow got=%b exp=1", overflow); end
        repeat (4) idle();
        cfg(2, -8, 1);
        repeat (2) step(0, 0, 3'b100, 3'b000, 0, 0, 0, 0);
        step(0, 1, 3'b000, 3'b000, 0, 0, 0, 0);
        checks++; if (int'(bus.bad_tokens_out) !== -8 || int'(bus.good_tokens_out) !== 0) begin failures++; $display("FAIL sat_neg got=%0d/%0d exp=0/-8", bus.good_tokens_out, bus.bad_tokens_out); end
        repeat (4) idle();
    endtask

    task automatic test_event_boundaries();
        cfg(0, 3, 0);
        step(0, 0, 3'b001, 3'b001, 0, 0, 0, 0);
        step(0, 1, 3'b000, 3'b000, 0, 0, 0, 0);
        checks++; if (int'(bus.good_tokens_out) !== 0) begin failures++; $display("FAIL start_stop_same got=%0d exp=0", bus.good_tokens_out); end
        repeat (4) idle();
        step(0, 1, 3'b001, 3'b000, 0, 0, 0, 0);
        checks++; if (int'(bus.good_tokens_out) !== 0) begin failures++; $display("FAIL tick_cycle_event_now got=%0d exp=0", bus.good_tokens_out); end
        repeat (4) idle();
        step(0, 1, 3'b000, 3'b000, 0, 0, 0, 0);
        checks++; if (int'(bus.good_tokens_out) !== 3) begin failures++; $display("FAIL tick_cycle_event_next got=%0d exp=3", bus.good_tokens_out); end
        repeat (4) idle();
    endtask

    task automatic test_tick_busy();
        checks++; if (tick_overrun !== 1'b0) begin failures++; $display("FAIL overrun_pre got=%b exp=0", tick_overrun); end
        step(0, 1, 3'b000, 3'b000, 0, 0, 0, 0);          // T
        step(0, 0, 3'b001, 3'b000, 0, 0, 0, 0);          // T+1, event for next window
        step(0, 1, 3'b000, 3'b000, 0, 0, 0, 0);          // T+2, ignored tick
        checks++; if (tick_overrun !== 1'b1) begin failures++; $display("FAIL overrun_flag got=%b exp=1", tick_overrun); end
        checks++; if (bus.proc_instruction !== 4'b1000) begin failures++; $display("FAIL overrun_no_restart got=%b exp=1000", bus.proc_instruction); end
        idle();                                          // T+3
        checks++; if (bus.proc_instruction !== 4'b1001 || busy !== 1'b1) begin failures++; $display("FAIL overrun_countdown got instr=%b busy=%b exp=1001/1", bus.proc_instruction, busy); end
        idle();                                          // T+4
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL overrun_idle got busy=%b exp=0", busy); end
        step(0, 1, 3'b000, 3'b000, 0, 0, 0, 0);          // T+5, accepted
        checks++; if (busy !== 1'b1 || bus.proc_instruction !== 4'b0000 || int'(bus.good_tokens_out) !== 3) begin failures++; $display("FAIL tick_t5 got busy=%b instr=%b good=%0d exp=1/0000/3", busy, bus.proc_instruction, bus.good_tokens_out); end
        repeat (4) idle();
    endtask

    task automatic test_config();
        step(0, 0, 3'b001, 3'b000, 1, 0, 5, 0);          // write 5 while src0 fires with old 3
        step(0, 1, 3'b000, 3'b000, 0, 0, 0, 0);
        checks++; if (int'(bus.good_tokens_out) !== 3) begin failures++; $display("FAIL cfg_old_weight got=%0d exp=3", bus.good_tokens_out); end
        repeat (4) idle();
        cfg(3, 1, 0);                                    // out-of-range address
        step(0, 0, 3'b111, 3'b000, 0, 0, 0, 0);
        step(0, 1, 3'b000, 3'b000, 0, 0, 0, 0);
        checks++; if (int'(bus.good_tokens_out) !== 5 || int'(bus.bad_tokens_out) !== -6) begin failures++; $display("FAIL cfg_bad_addr got=%0d/%0d exp=5/-6", bus.good_tokens_out, bus.bad_tokens_out); end
        repeat (4) idle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            bit         r  = ($urandom_range(0, 149) == 0);
            bit         tk = ($urandom_range(0, 3) == 0);
            logic [2:0] st = 3'($urandom) & 3'($urandom);
            logic [2:0] sp = 3'($urandom) & 3'($urandom);
            bit         we = ($urandom_range(0, 5) == 0);
            int         ad = int'($urandom_range(0, 3));
            int         wt = int'($urandom_range(0, 15)) - 8;
            bit         bd = 1'($urandom_range(0, 1));
            step(r, tk, st, sp, we, ad, wt, bd);
            checks++;
            if (bus.proc_enable !== (m_phase != 0) || busy !== (m_phase != 0) || int'(bus.proc_instruction) !== exp_instr[m_phase]) begin
                failures++; $display("FAIL rand_ctrl cyc=%0d got en=%b busy=%b instr=%b exp phase=%0d instr=%0d", c, bus.proc_enable, busy, bus.proc_instruction, m_phase, exp_instr[m_phase]);
            end
            checks++;
            if (int'(bus.good_tokens_out) !== m_out_g || int'(bus.bad_tokens_out) !== m_out_b) begin
                failures++; $display("FAIL rand_tokens cyc=%0d got=%0d/%0d exp=%0d/%0d", c, bus.good_tokens_out, bus.bad_tokens_out, m_out_g, m_out_b);
            end
            checks++;
            if (overflow !== m_ovf || tick_overrun !== m_ovr) begin
                failures++; $display("FAIL rand_flags cyc=%0d got ovf=%b ovr=%b exp=%b/%b", c, overflow, tick_overrun, m_ovf, m_ovr);
            end
        end
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; src_start = '0; src_stop = '0;
        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_weight = '0; bus.cfg_is_bad = 1'b0;
        @(negedge clock);
        test_reset();
        test_basic();
        test_saturation();
        test_event_boundaries();
        test_tick_busy();
        test_config();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
